// File: rtl/ll_monitor.sv
// -----------------------------------------------------------------------------
// ll_monitor
//
// Multi-channel load-linked / store-conditional reservation monitor. Holds one
// link (valid bit plus linked address) for each hardware channel. An LL commit
// sets a link at writeback. An SC queries its link in MEM and consumes it.
// Links are also dropped by an exception flush, by a conflicting store (snoop),
// by a successful SC from another channel to the same granule and, in the
// timeout build, by link expiry.
//
// Build option:
//   LL_TIMEOUT_EN  when defined, every channel carries an age counter. A link
//                  set at edge N is dropped at edge N+TIMEOUT unless a new LL
//                  refreshes it first. When undefined, a link lasts until the
//                  next LL, SC, snoop, flush or reset.
//
// Parameters:
//   ADDR_W    physical address width
//   CH        number of channels (>= 1)
//   CH_W      channel index width
//   GRAN_LSB  address bits below this index are ignored when matching
//             (reservation granule = 2^GRAN_LSB bytes)
//   TIMEOUT   link lifetime in cycles (>= 2), used only with LL_TIMEOUT_EN
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active low
//   flush       exception/ERET flush; clears every link, overrides all requests
//   ll_we       LL commit
//   ll_ch       channel of the LL
//   ll_addr     LL address
//   sc_req      SC query; consumes the link of sc_ch whatever the outcome
//   sc_ch       channel of the SC
//   sc_addr     SC address
//   sc_ok       combinational SC success, computed from the pre-edge state
//   snoop_we    a store from any source is committing
//   snoop_addr  address of that store
//   rd_ch       channel select for the LLAddr read-back
//   lladdr_o    combinational linked address of rd_ch (returned even when the
//               link is invalid; 0 for an out-of-range channel)
//   llbit_o     registered per-channel link valid bits
//
// Interface semantics: there is no valid/ready handshake. Every request input
// is a single-cycle strobe qualified only by its own enable (ll_we, sc_req,
// snoop_we, flush) and is always accepted in the cycle it is presented. A
// channel index at or above CH matches no channel, so the request is ignored.
// -----------------------------------------------------------------------------
module ll_monitor #(
  parameter int ADDR_W   = 32,
  parameter int CH       = 2,
  parameter int CH_W     = (CH > 1) ? $clog2(CH) : 1,
  parameter int GRAN_LSB = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ll_we,
  input  logic [CH_W-1:0]   ll_ch,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic              sc_req,
  input  logic [CH_W-1:0]   sc_ch,
  input  logic [ADDR_W-1:0] sc_addr,
  output logic              sc_ok,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [ADDR_W-1:0] lladdr_o,
  output logic [CH-1:0]     llbit_o
);

  // Elaboration-time parameter sanity checks.
  generate
    if (CH < 1) begin : g_bad_ch
      $error("ll_monitor: CH must be at least 1");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
      $error("ll_monitor: TIMEOUT must be at least 2");
    end
  endgenerate

  // Granule mask: ones on the address bits that take part in matching.
  localparam logic [ADDR_W-1:0] GRAN_MASK = {ADDR_W{1'b1}} << GRAN_LSB;

  // Two addresses fall in the same reservation granule when they agree on
  // every bit above GRAN_LSB.
  function automatic logic granule_match(input logic [ADDR_W-1:0] a,
                                         input logic [ADDR_W-1:0] b);
    return ((a ^ b) & GRAN_MASK) == '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Link state
  // ---------------------------------------------------------------------------
  logic [CH-1:0]     valid_q;
  logic [ADDR_W-1:0] addr_q [CH];

`ifdef LL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]  cnt_q [CH];
`endif

  // ---------------------------------------------------------------------------
  // Channel selection for the SC query and the LLAddr read-back. Looping over
  // the real channels means an out-of-range index selects nothing, which gives
  // sc_ok = 0 and lladdr_o = 0 without a separate range check.
  // ---------------------------------------------------------------------------
  logic              sc_valid;
  logic [ADDR_W-1:0] sc_link_addr;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    sc_valid     = 1'b0;
    sc_link_addr = '0;
    rd_addr      = '0;
    for (int c = 0; c < CH; c++) begin
      if (sc_ch == CH_W'(c)) begin
        sc_valid     = valid_q[c];
        sc_link_addr = addr_q[c];
      end
      if (rd_ch == CH_W'(c)) begin
        rd_addr = addr_q[c];
      end
    end
  end

  // A same-cycle flush wins over the SC, so it can never report success.
  assign sc_ok    = sc_req & ~flush & sc_valid & granule_match(sc_link_addr, sc_addr);
  assign lladdr_o = rd_addr;
  assign llbit_o  = valid_q;

  // ---------------------------------------------------------------------------
  // Kill detection. A committing store to a linked granule breaks that link.
  // A successful SC is itself a store, so it breaks the matching links of the
  // other channels too. Its own link is consumed by the SC rule anyway.
  // ---------------------------------------------------------------------------
  logic [CH-1:0] kill;

  always_comb begin
    kill = '0;
    for (int c = 0; c < CH; c++) begin
      kill[c] = (snoop_we & granule_match(addr_q[c], snoop_addr)) |
                (sc_ok    & granule_match(addr_q[c], sc_addr));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state update. Priority, highest first: reset, flush, LL on this
  // channel, SC on this channel, kill, timeout. An LL therefore beats a
  // same-cycle snoop or SC kill on its own channel, and the new link survives.
  // The linked address changes only on LL or reset, so the LLAddr read-back
  // keeps returning it after the link is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int c = 0; c < CH; c++) begin
        addr_q[c] <= '0;
`ifdef LL_TIMEOUT_EN
        cnt_q[c]  <= '0;
`endif
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (ll_we && (ll_ch == CH_W'(c))) begin
          valid_q[c] <= 1'b1;
          addr_q[c]  <= ll_addr;
`ifdef LL_TIMEOUT_EN
          cnt_q[c]   <= '0;
`endif
        end else if (sc_req && (sc_ch == CH_W'(c))) begin
          valid_q[c] <= 1'b0;
        end else if (kill[c]) begin
          valid_q[c] <= 1'b0;
`ifdef LL_TIMEOUT_EN
        end else if (valid_q[c]) begin
          // The counter holds the number of edges since the LL. The link is
          // dropped at the edge where it would reach TIMEOUT, so the counter
          // never passes TIMEOUT-1 and never wraps while the link is live.
          if (cnt_q[c] == CNT_LAST) begin
            valid_q[c] <= 1'b0;
          end else begin
            cnt_q[c] <= cnt_q[c] + CNT_W'(1);
          end
`endif
        end
      end
    end
  end

endmodule

// File: doc/ll_monitor.md
# ll_monitor

Multi-channel load-linked/store-conditional reservation monitor; parametrised successor to the single LLbit register. Tracks one link (valid bit plus linked address) per hardware channel. Resolves SC success against the link and clears links on exception flush, conflicting stores (snoop) and, optionally, link timeout. Sits beside the MEM/WB stages: LL sets the link at writeback, SC queries it in MEM, and the CP0 LLAddr path reads it back.

## Interface
- `ADDR_W`, 32, physical address width.
- `CH`, 2, number of channels (links), ≥1.
- `CH_W`, `$clog2(CH)` (min 1), channel-index width.
- `GRAN_LSB`, 2, low address bits ignored in matching (reservation granule = 2^GRAN_LSB bytes).
- `TIMEOUT`, 1024, link lifetime in cycles, ≥2; used only with `LL_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `flush` in 1: exception/ERET flush; clears all links.
- `ll_we` in 1: LL commit.
- `ll_ch` in CH_W: channel for the LL.
- `ll_addr` in ADDR_W: LL address.
- `sc_req` in 1: SC query/consume.
- `sc_ch` in CH_W: channel for the SC.
- `sc_addr` in ADDR_W: SC address.
- `sc_ok` out 1: combinational SC success.
- `snoop_we` in 1: a store (any source) is committing.
- `snoop_addr` in ADDR_W: store address.
- `rd_ch` in CH_W: channel select for the LLAddr read.
- `lladdr_o` out ADDR_W: combinational linked address of `rd_ch`.
- `llbit_o` out CH: registered per-channel link valid bits.

## Operation
- Per-channel state: `valid[c]`, `addr[c]` (ADDR_W), and, with the macro, `cnt[c]`.
- Match: `A[ADDR_W-1:GRAN_LSB] == B[ADDR_W-1:GRAN_LSB]`.
- `sc_ok = sc_req & ~flush & valid[sc_ch] & match(addr[sc_ch], sc_addr)`; evaluated on pre-edge state.
- Next-state update per channel c, highest priority first:
  1. `rst`=0: `valid`=0, `addr`=0, `cnt`=0.
  2. `flush`=1: `valid[c]`=0. `addr` is held; all other requests in the cycle are ignored.
  3. `ll_we & ll_ch==c`: `valid`=1, `addr`=`ll_addr`, `cnt`=0.
  4. `sc_req & sc_ch==c`: `valid`=0, whether the SC passes or fails.
  5. Kill: `valid[c]`=0 if either condition holds:
     - `snoop_we & match(addr[c], snoop_addr)`;
     - `sc_ok & match(addr[c], sc_addr)` (a successful SC is a store to other channels).
  6. Timeout, macro only: if `valid[c]` and `cnt[c]==TIMEOUT-1`, then `valid[c]`=0; else `cnt[c]+1` while valid.
- An LL beats a same-cycle snoop/SC kill on its own channel. The new link survives.
- `addr[c]` changes only on LL or reset. `lladdr_o` returns it even when the link is invalid (CP0 LLAddr semantics).
- Out-of-range `ll_ch`/`sc_ch`/`rd_ch` (≥CH) is ignored. `sc_ok`=0 and `lladdr_o`=0.

## Timing
- Reset values: `llbit_o`=0, `lladdr_o`=0, `sc_ok`=0 while `sc_req`=0.
- LL at edge N: `llbit_o[c]`=1 after edge N. An SC in cycle N+1 sees the link.
- SC: `sc_ok` is valid in the same cycle as `sc_req` (0 cycles). The link clears at that cycle's edge, so a back-to-back second SC fails.
- Snoop/flush: effective at the next edge. An SC in the same cycle as a matching snoop still sees the pre-edge state and succeeds; ordering is resolved upstream.
- Same-cycle `flush` forces `sc_ok`=0.
- Timeout: a link set at edge N clears at edge N+TIMEOUT unless refreshed by a new LL.
- `cnt` width is `$clog2(TIMEOUT)`; it saturates at `TIMEOUT-1` and never wraps while valid.

## Configuration
- `LL_TIMEOUT_EN` defined: per-channel counters and expiry rule 6 are compiled in. This bounds livelock from a link held across a long-running loop.
- Not defined: no counters, no rule 6. Links persist until LL/SC/snoop/flush/reset.

## Test plan
- Reset then LL: hold `rst`=0 for 2 cycles, then LL ch0 @0x1000 → `llbit_o`=2'b01, `lladdr_o`(rd_ch=0)=0x1000. SC ch0 @0x1002 next cycle → `sc_ok`=1 (granule match); `llbit_o`=0 after the edge.
- Snoop kill: LL ch0 @0x1000, LL ch1 @0x2000; snoop @0x1003 → `llbit_o`=2'b10. SC ch0 @0x1000 → `sc_ok`=0.
- Cross-channel SC: both channels linked @0x3000; SC ch1 @0x3000 → `sc_ok`=1; next cycle `llbit_o`=2'b00.
- Priority: LL ch0 @0x4000 with same-cycle snoop @0x4000 → `llbit_o[0]`=1. Flush with same-cycle LL ch1 and SC ch0 → `sc_ok`=0, `llbit_o`=0, `lladdr_o`(ch1) unchanged.
- Timeout (`LL_TIMEOUT_EN`, TIMEOUT=8): LL ch0 at edge N → `llbit_o[0]`=1 through edge N+7, 0 after edge N+8. Re-LL at N+5 extends expiry to N+13. Without the macro, the bit is still 1 at N+100.
- Reset mid-link: LL ch1, then drive `rst`=0 for 1 cycle → `llbit_o`=0, `lladdr_o`=0. SC ch1 fails.
